// File: rtl/sio_l2b_rdrsp_asm.sv
// Per-bank L2B read-response assembler: captures 17-beat responses into an
// NBUF-entry store-and-forward buffer and replays them with valid/ready.
module sio_l2b_rdrsp_asm #(
    parameter int unsigned NBUF  = 2,
    parameter int unsigned NBEAT = 17
) (
    input  logic        iol2clk,
    input  logic        rst_l,
    input  logic        l2b_sio_ctag_vld,
    input  logic [31:0] l2b_sio_data,
    input  logic [1:0]  l2b_sio_parity,
    input  logic        l2b_sio_ue_err,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_data,
    output logic        rsp_sop,
    output logic        rsp_eop,
    output logic [15:0] rsp_ctag,
    output logic        rsp_pe,
    output logic        rsp_ue,
    output logic        sio_l2b_cred,
    output logic        ovf_err,
    output logic        proto_err
);

    localparam int unsigned PW = (NBUF > 2) ? 2 : 1;
    localparam int unsigned CW = 5;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_DROP = 2'd2
    } cap_state_e;

    cap_state_e        state_q, state_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [NBUF-1:0]   full_q, full_d, epe_q, epe_d, eue_q, eue_d;
    logic              pe_acc_q, pe_acc_d, ue_acc_q, ue_acc_d;
    logic              ovf_q, ovf_d, proto_q, proto_d;
    logic [CW-1:0]     dcnt_q, dcnt_d;
    logic              vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic [DW-1:0]     data_q, data_d;
    logic [15:0]       ctag_q, ctag_d;
    logic              pe_q, pe_d, ue_q, ue_d, cred_q, cred_d;

    logic [DW-1:0]     mem_q [NBUF][NBEAT];
    logic              mem_we;
    logic [CW-1:0]     widx;
    logic              beat_pe, cap_done, ld;
    logic [PW-1:0]     ld_e;

    assign beat_pe = (^l2b_sio_data[31:16] ^ l2b_sio_parity[1]) |
                     (^l2b_sio_data[15:0]  ^ l2b_sio_parity[0]);
    assign widx    = (state_q == ST_IDLE) ? '0 : bcnt_q;

    // Packet storage; no reset needed, entries are qualified by full_q.
    always_ff @(posedge iol2clk) begin
        if (mem_we) begin
            mem_q[wp_q][widx] <= l2b_sio_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        full_d   = full_q;
        epe_d    = epe_q;
        eue_d    = eue_q;
        pe_acc_d = pe_acc_q;
        ue_acc_d = ue_acc_q;
        ovf_d    = ovf_q;
        proto_d  = proto_q;
        dcnt_d   = dcnt_q;
        vld_d    = vld_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        data_d   = data_q;
        ctag_d   = ctag_q;
        pe_d     = pe_q;
        ue_d     = ue_q;
        cred_d   = 1'b0;
        mem_we   = 1'b0;
        cap_done = 1'b0;
        ld       = 1'b0;
        ld_e     = rp_q;

        // Capture side
        case (state_q)
            ST_IDLE: begin
                if (l2b_sio_ctag_vld) begin
                    bcnt_d = CW'(1);
                    if (full_q[wp_q]) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        pe_acc_d = beat_pe;
                        ue_acc_d = l2b_sio_ue_err;
                        state_d  = ST_CAPT;
                    end
                end
            end
            ST_CAPT: begin
                mem_we   = 1'b1;
                pe_acc_d = pe_acc_q | beat_pe;
                ue_acc_d = ue_acc_q | l2b_sio_ue_err;
                if (l2b_sio_ctag_vld) proto_d = 1'b1;
                if (bcnt_q == LAST_BEAT) begin
                    cap_done     = 1'b1;
                    full_d[wp_q] = 1'b1;
                    epe_d[wp_q]  = pe_acc_d;
                    eue_d[wp_q]  = ue_acc_d;
                    wp_d         = wp_q + PW'(1);
                    state_d      = ST_IDLE;
                end else begin
                    bcnt_d = bcnt_q + CW'(1);
                end
            end
            ST_DROP: begin
                if (l2b_sio_ctag_vld) proto_d = 1'b1;
                if (bcnt_q == LAST_BEAT) state_d = ST_IDLE;
                else                     bcnt_d  = bcnt_q + CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Drain side; an entry completing this cycle is forwarded without a bubble
        if (!vld_q) begin
            ld = full_q[rp_q] | (cap_done && (wp_q == rp_q));
        end else if (rsp_rdy) begin
            if (dcnt_q == LAST_BEAT) begin
                full_d[rp_q] = 1'b0;
                rp_d         = rp_q + PW'(1);
                cred_d       = 1'b1;
                ld_e         = rp_q + PW'(1);
                ld           = full_q[ld_e] | (cap_done && (wp_q == ld_e));
                vld_d        = 1'b0;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
                data_d = mem_q[rp_q][dcnt_d];
                sop_d  = 1'b0;
                eop_d  = (dcnt_d == LAST_BEAT);
            end
        end

        if (ld) begin
            vld_d  = 1'b1;
            dcnt_d = '0;
            data_d = mem_q[ld_e][0];
            ctag_d = mem_q[ld_e][0][15:0];
            sop_d  = 1'b1;
            eop_d  = 1'b0;
            pe_d   = epe_d[ld_e];
            ue_d   = eue_d[ld_e];
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= ST_IDLE;
            bcnt_q   <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            full_q   <= '0;
            epe_q    <= '0;
            eue_q    <= '0;
            pe_acc_q <= 1'b0;
            ue_acc_q <= 1'b0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
            dcnt_q   <= '0;
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            data_q   <= '0;
            ctag_q   <= '0;
            pe_q     <= 1'b0;
            ue_q     <= 1'b0;
            cred_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            full_q   <= full_d;
            epe_q    <= epe_d;
            eue_q    <= eue_d;
            pe_acc_q <= pe_acc_d;
            ue_acc_q <= ue_acc_d;
            ovf_q    <= ovf_d;
            proto_q  <= proto_d;
            dcnt_q   <= dcnt_d;
            vld_q    <= vld_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            data_q   <= data_d;
            ctag_q   <= ctag_d;
            pe_q     <= pe_d;
            ue_q     <= ue_d;
            cred_q   <= cred_d;
        end
    end

    assign rsp_vld      = vld_q;
    assign rsp_data     = data_q;
    assign rsp_sop      = sop_q;
    assign rsp_eop      = eop_q;
    assign rsp_ctag     = ctag_q;
    assign rsp_pe       = pe_q;
    assign rsp_ue       = ue_q;
    assign sio_l2b_cred = cred_q;
    assign ovf_err      = ovf_q;
    assign proto_err    = proto_q;

endmodule

// File: doc/sio_l2b_rdrsp_asm.md
Name: sio_l2b_rdrsp_asm

Overview:
Per-bank read-response assembler in the SIO. It sits directly downstream of one L2 bank's read-return interface (l2b*_sio_ctag_vld, data, parity, ue_err). It captures each 17-beat response (1 header beat + 16 data beats), checks parity per half-word, and flags uncorrectable errors. Completed packets are stored in an NBUF-entry store-and-forward buffer and replayed downstream with a valid/ready handshake; one credit per freed entry is returned to the L2 bank.

Parameters:
NBUF, 2, number of packet buffer entries (power of 2, 2..4)
NBEAT, 17, beats per response (header + 16 data words); fixed, not meant to be overridden

Ports:
iol2clk  input  1  I/O-L2 clock; all state on rising edge
rst_l  input  1  asynchronous active-low reset
l2b_sio_ctag_vld  input  1  marks beat 0 (header) of a response
l2b_sio_data  input  32  header/data beat
l2b_sio_parity  input  2  even parity: [1] over data[31:16], [0] over data[15:0]
l2b_sio_ue_err  input  1  uncorrectable error, valid on any beat of the packet
rsp_vld  output  1  downstream beat valid
rsp_rdy  input  1  downstream accepts beat
rsp_data  output  32  beat payload (header on sop)
rsp_sop  output  1  beat 0 of packet
rsp_eop  output  1  beat 16 of packet
rsp_ctag  output  16  header[15:0] of current packet, stable for whole packet
rsp_pe  output  1  parity error on any beat of current packet, stable for whole packet
rsp_ue  output  1  ue_err seen on any beat of current packet, stable for whole packet
sio_l2b_cred  output  1  one-cycle credit-return pulse per freed entry
ovf_err  output  1  sticky: response arrived with no free entry
proto_err  output  1  sticky: ctag_vld during beats 1..16

Behaviour:
- Reset (async assert, sync deassert assumed from the clock domain): all outputs 0. Buffer empty, capture FSM IDLE, read/write pointers 0, sticky flags cleared. A packet in flight at reset is discarded and returns no credit.
- Capture FSM IDLE/CAPT, with beat counter bcnt[4:0]:
  - IDLE with ctag_vld=1 and a free entry: write the header to entry[wp] word 0, go to CAPT, bcnt=1.
  - CAPT: each cycle, unconditionally write data into word bcnt. At bcnt=16, mark the entry full, advance wp mod NBUF, return to IDLE.
  - No beat gaps: L2B drives 17 consecutive cycles.
- Per-entry pe = OR over beats of (^data[31:16]^parity[1]) | (^data[15:0]^parity[0]). Per-entry ue = OR over beats of ue_err. Both are accumulated during capture and stored with the entry.
- Overflow: ctag_vld in IDLE with all NBUF entries full.
  - The packet is dropped: its 17 beats are ignored via a DROP state with the same counter.
  - ovf_err is set and no credit is returned.
  - An entry freed in the same cycle does not count; the free takes effect the next cycle.
- Protocol error: ctag_vld=1 while in CAPT with bcnt 1..16 sets proto_err. The beat is still stored as data and the capture continues unchanged. The same rule applies in DROP.
- Drain (store-and-forward):
  - rsp_vld rises no earlier than the cycle after the beat-16 write of an entry, registered.
  - Beats are presented from entry[rp], word index dcnt 0..16.
  - A beat advances only when rsp_vld & rsp_rdy. While stalled, rsp_data, sop, eop, ctag, pe and ue hold.
  - rsp_sop = (dcnt==0); rsp_eop = (dcnt==16).
  - On the eop handshake: free the entry, advance rp, pulse sio_l2b_cred the next cycle. If the next entry is already full, rsp_vld stays high with no bubble.
- Latency: with rsp_rdy=1 constantly, first rsp beat is 1 cycle after the capture of beat 16. Full throughput is 1 beat/cycle.
- Simultaneous capture and drain of different entries is fully independent. Capture and drain never target the same entry.
- Credits: the bank starts with NBUF credits (upstream convention). This block only emits return pulses, never more than 1 per cycle.

Test Plan:
- Single clean response: ctag_vld with header 0x0000_00A5, data words 0x1000_0000+i (i=1..16) with correct parity, rsp_rdy=1 -> 17 rsp beats starting 1 cycle after input beat 16; sop on 0xA5 header, eop on 0x1000_0010; rsp_ctag=0x00A5, pe=0, ue=0; one cred pulse 1 cycle after eop.
- Parity error: flip parity[0] on beat 5 -> rsp_pe=1 on all 17 beats of that packet only; next clean packet has pe=0.
- UE: ue_err=1 on beat 12 -> rsp_ue=1 for the whole packet; data passes through unmodified.
- Backpressure/overflow (NBUF=2): rsp_rdy=0, send 3 back-to-back responses -> first two buffered, third dropped, ovf_err=1, zero credits. Then rsp_rdy=1 -> 34 beats in order, 2 cred pulses.
- Stall mid-packet: toggle rsp_rdy every other cycle -> no beat duplicated or lost, outputs hold while stalled, eop after exactly 17 handshakes.
- Protocol/reset: ctag_vld on beat 8 -> proto_err=1, packet still 17 beats. Assert rst_l low mid-drain -> all outputs 0 immediately (async), no credit, next response captured normally.
